// File: rtl/npu_pkg.sv
// Shared definitions for the classifier output path: FSM encoding and
// default sizing for the score datapath.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } argmax_state_e;

    localparam int NUM_CLASSES_MNIST = 10;
    localparam int SCORE_WIDTH       = 8;

endpackage : npu_pkg

// File: rtl/score_cmp.sv
// Combinational signed greater-than between two class scores.
// Comparing at the native width avoids any extension artefacts on the
// most-negative value.
module score_cmp #(
    parameter int WIDTH = npu_pkg::SCORE_WIDTH
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic                    gt_o
);

    // Strict compare: equal scores never report greater, so ties keep the earlier lane
    always_comb begin
        gt_o = (a_i > b_i);
    end

endmodule : score_cmp

// File: rtl/score_argmax.sv
// Sequential argmax: walks the external score mux one lane per cycle,
// keeps the running maximum and offers the winner on a valid/ready port.
module score_argmax
    import npu_pkg::*;
#(
    parameter int WIDTH       = SCORE_WIDTH,
    parameter int SEL_WIDTH   = 4,
    parameter int NUM_CLASSES = NUM_CLASSES_MNIST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [SEL_WIDTH-1:0]    sel,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_WIDTH-1:0]    class_out,
    output logic signed [WIDTH-1:0] max_out
);

    // Final lane index; the scan stops here so unused mux lanes are never read
    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_CLASSES - 1);

    argmax_state_e state_q, state_d;

    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [SEL_WIDTH-1:0]    best_idx_q, best_idx_d;
    logic [SEL_WIDTH-1:0]    class_q, class_d;
    logic signed [WIDTH-1:0] best_val_q, best_val_d;
    logic signed [WIDTH-1:0] max_q, max_d;

    logic                    last_lane;
    logic                    cand_gt;
    logic                    take_cand;
    logic signed [WIDTH-1:0] scan_val;
    logic [SEL_WIDTH-1:0]    scan_idx;

    score_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a_i  (data_in),
        .b_i  (best_val_q),
        .gt_o (cand_gt)
    );

    assign last_lane = (sel_q == LAST_SEL);
    // Lane 0 seeds the running best regardless of what was left from a prior scan
    assign take_cand = (sel_q == '0) || cand_gt;
    assign scan_val  = take_cand ? data_in : best_val_q;
    assign scan_idx  = take_cand ? sel_q   : best_idx_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)     state_d = SCAN;
            SCAN:    if (last_lane) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output logic decoded from the current state
    always_comb begin
        busy      = (state_q == SCAN) || (state_q == HOLD);
        out_valid = (state_q == HOLD);
    end

    // Datapath next values: lane counter, running best and the published result
    always_comb begin
        sel_d      = sel_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        class_d    = class_q;
        max_d      = max_q;
        unique case (state_q)
            IDLE: begin
                sel_d = '0;
            end
            SCAN: begin
                best_idx_d = scan_idx;
                best_val_d = scan_val;
                if (last_lane) begin
                    // Publish including the compare against the last lane
                    class_d = scan_idx;
                    max_d   = scan_val;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    sel_d = '0;
                end
            end
            default: begin
                sel_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            class_q    <= '0;
            max_q      <= '0;
        end else begin
            sel_q      <= sel_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            class_q    <= class_d;
            max_q      <= max_d;
        end
    end

    assign sel       = sel_q;
    assign class_out = class_q;
    assign max_out   = max_q;

endmodule : score_argmax
